vsetvl_ctrl: RTL
================

// Module: vsetvl_ctrl
// PURPOSE
//  Writer side of the vl/vtype CSR ports of the vector register file (vl_in/vl_wen, vtype_in/vtype_wen).
//  Executes vsetvl-class requests from the decode stage:
//   - computes VLMAX from vtype and VLEN
//   - picks the new vl from the AVL source
//   - writes vl and vtype into the register file
//   - returns the granted vl (and vill) to the scalar writeback path.
// PARAMETERS
//  VLEN    128  vector register width in bits
//  AVL_W   32   width of scalar AVL operand
//  VL_W    9    width of vl, matches register-file vl port
//  VT_W    7    width of vtype: [2:0] vlmul, [5:3] vsew, [6] vta
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      controller can accept a request
//  req_avl      in   AVL_W  AVL from rs1
//  req_avl_sel  in   2      0=use req_avl, 1=AVL=max (rs1=x0,rd!=x0), 2=keep current vl, 3=reserved
//  req_vtype    in   VT_W   requested vtype
//  cur_vl       in   VL_W   current vl read back from register file
//  vl_in        out  VL_W   vl write data to register file
//  vl_wen       out  1      vl write enable
//  vtype_in     out  VT_W   vtype write data
//  vtype_wen    out  1      vtype write enable
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      response consumer ready
//  rsp_vl       out  VL_W   granted vl (rd writeback value)
//  rsp_vill     out  1      requested vtype illegal
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FSM->IDLE; all outputs 0 except req_ready=1.
//   - A write or response in flight is dropped; no wen pulses after reset.
//  FSM IDLE->CALC->WRITE->RESP->IDLE.
//  IDLE:
//   - req_ready=1.
//   - On req_valid, capture avl/avl_sel/vtype/cur_vl and go to CALC.
//  CALC (1 cycle): register vlmax and vill.
//   - vsew>3 -> vill.
//   - vlmul==4 -> vill.
//   - vlmul in 0..3: vlmax = (VLEN>>(3+vsew)) << vlmul.
//   - vlmul in 5..7: vlmax = (VLEN>>(3+vsew)) >> (8-vlmul).
//   - vlmax==0 -> vill.
//   - avl_sel==3 -> vill.
//  WRITE (1 cycle): vl_wen=vtype_wen=1 for exactly this cycle.
//   - vill:  vl_in=0, vtype_in=0.
//   - Else:  vtype_in=req_vtype, vl_in=min(AVL,vlmax).
//   - AVL source: sel0 -> req_avl (full AVL_W compare, no truncation before min); sel1 -> vlmax; sel2 -> cur_vl.
//   - sel2 with cur_vl>vlmax is clipped to vlmax.
//  RESP:
//   - rsp_valid=1; rsp_vl/rsp_vill held stable until rsp_valid&&rsp_ready.
//   - On handshake -> IDLE.
//  Latency: accept at edge N; wen high in cycle N+2; rsp_valid from cycle N+3.
//  Throughput: one request per 4 cycles minimum.
//  req_ready=0 outside IDLE; req_valid there is ignored (must be held by the producer).
//  vl_in/vtype_in are 0 whenever wen=0.
//  rsp_vl/rsp_vill are 0 whenever rsp_valid=0.
// TESTING
//  1. rst=0 mid-WRITE -> vl_wen=vtype_wen=rsp_valid=0 immediately, req_ready=1.
//  2. vtype=7'b0_000_000 (e8,m1), sel0, avl=5 -> vl_in=5 in cycle N+2, rsp_vl=5, vill=0.
//  3. vtype e8,m8 (vlmul=3), sel1 -> vl_in=128.
//     Same request with avl=32'hFFFF_FFFF, sel0 -> vl_in=128.
//  4. vtype vsew=2 (e32), vlmul=7 (mf2), sel0, avl=9 -> vlmax=2, vl_in=2.
//  5. vlmul=4 -> vill=1, vl_in=0, vtype_in=0, both wen pulse once.
//  6. sel2, cur_vl=100, vtype e16,m1 (vlmax=8) -> vl_in=8.
//     Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_vl stable, req_ready=0 throughout.

Source files
------------

// File: rtl/vsetvl_ctrl.sv
// Executes vsetvl-class requests: derives VLMAX from vtype, grants vl from the AVL source,
// writes vl/vtype into the vector register file and returns the granted vl to the scalar side.
module vsetvl_ctrl #(
    parameter int VLEN  = 128,
    parameter int AVL_W = 32,
    parameter int VL_W  = 9,
    parameter int VT_W  = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [AVL_W-1:0] i_req_avl,
    input  logic [1:0]       i_req_avl_sel,
    input  logic [VT_W-1:0]  i_req_vtype,
    input  logic [VL_W-1:0]  i_cur_vl,
    output logic [VL_W-1:0]  o_vl_in,
    output logic             o_vl_wen,
    output logic [VT_W-1:0]  o_vtype_in,
    output logic             o_vtype_wen,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [VL_W-1:0]  o_rsp_vl,
    output logic             o_rsp_vill,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // valid holds its payload stable until that edge and never depends on ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [AVL_W-1:0] r_avl;
    logic [1:0]       r_avl_sel;
    logic [VT_W-1:0]  r_vtype;
    logic [VL_W-1:0]  r_cur_vl;
    logic [AVL_W-1:0] r_vlmax;
    logic             r_vill;
    logic [VL_W-1:0]  r_rsp_vl;
    logic             r_rsp_vill;

    logic [2:0]       w_vlmul;
    logic [2:0]       w_vsew;
    logic [AVL_W-1:0] w_base;
    logic [AVL_W-1:0] w_vlmax;
    logic             w_vill;
    logic [AVL_W-1:0] w_avl;
    logic [AVL_W-1:0] w_vl_full;
    logic [VL_W-1:0]  w_vl;

    assign w_vlmul = r_vtype[2:0];
    assign w_vsew  = r_vtype[5:3];
    assign w_base  = AVL_W'(VLEN) >> (32'd3 + 32'(w_vsew));

    always_comb begin
        w_vlmax = '0;
        if (w_vlmul < 3'd4) begin
            w_vlmax = w_base << w_vlmul;
        end else if (w_vlmul != 3'd4) begin
            w_vlmax = w_base >> (32'd8 - 32'(w_vlmul));
        end
        w_vill = (w_vsew > 3'd3) || (w_vlmul == 3'd4) || (w_vlmax == '0) || (r_avl_sel == 2'd3);
    end

    // Full-width compare so an oversized AVL saturates to VLMAX instead of wrapping.
    always_comb begin
        w_avl = r_vlmax;
        case (r_avl_sel)
            2'd0:    w_avl = r_avl;
            2'd2:    w_avl = AVL_W'(r_cur_vl);
            default: w_avl = r_vlmax;
        endcase
        w_vl_full = (w_avl < r_vlmax) ? w_avl : r_vlmax;
        w_vl      = VL_W'(w_vl_full);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_req_valid) w_next_state = CALC;
            CALC:    w_next_state = WRITE;
            WRITE:   w_next_state = RESP;
            RESP:    if (i_rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_avl      <= '0;
            r_avl_sel  <= '0;
            r_vtype    <= '0;
            r_cur_vl   <= '0;
            r_vlmax    <= '0;
            r_vill     <= 1'b0;
            r_rsp_vl   <= '0;
            r_rsp_vill <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && i_req_valid) begin
                r_avl     <= i_req_avl;
                r_avl_sel <= i_req_avl_sel;
                r_vtype   <= i_req_vtype;
                r_cur_vl  <= i_cur_vl;
            end
            if (r_state == CALC) begin
                r_vlmax <= w_vlmax;
                r_vill  <= w_vill;
            end
            if (r_state == WRITE) begin
                r_rsp_vl   <= r_vill ? '0 : w_vl;
                r_rsp_vill <= r_vill;
            end
        end
    end

    always_comb begin
        o_req_ready = (r_state == IDLE);
        o_vl_wen    = (r_state == WRITE);
        o_vtype_wen = (r_state == WRITE);
        o_vl_in     = (r_state == WRITE && !r_vill) ? w_vl : '0;
        o_vtype_in  = (r_state == WRITE && !r_vill) ? r_vtype : '0;
        o_rsp_valid = (r_state == RESP);
        o_rsp_vl    = (r_state == RESP) ? r_rsp_vl : '0;
        o_rsp_vill  = (r_state == RESP) ? r_rsp_vill : 1'b0;
        o_dbg_state = r_state;
    end

endmodule
